// File: rtl/bg_scroll_fetch.sv
// Background ROM address generator with horizontal room-scroll FSM.
// Optional BG_BORDER_EN forces a one-pixel black frame on the screen edge.
module bg_scroll_fetch #(
  parameter int IMG_W     = 160,
  parameter int IMG_H     = 120,
  parameter int SCALE_SH  = 2,
  parameter int NUM_ROOMS = 4,
  parameter int STEP      = 4,
  parameter int ADDR_W    = 17,
  localparam int RW = (NUM_ROOMS > 1) ? $clog2(NUM_ROOMS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              display_en,
  input  logic              frame_tick,
  input  logic              scroll_req,
  input  logic              scroll_dir,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic [4:0]        pal_index,
  output logic              pal_valid,
  output logic              busy,
  output logic              scroll_done,
  output logic [RW-1:0]     room
);

  localparam int STRIP_W = IMG_W * NUM_ROOMS;
  localparam int XW = $clog2(STRIP_W + 1);
  localparam int MW = $clog2(IMG_W + 1);

  localparam logic [9:0] CX_MAX = 10'(IMG_W - 1);
  localparam logic [9:0] CY_MAX = 10'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] SW_A = ADDR_W'(STRIP_W);
  localparam logic [MW-1:0] IMG_W_M = MW'(IMG_W);
  localparam logic [MW-1:0] STEP_M = MW'(STEP);
  localparam logic [RW-1:0] LAST_ROOM = RW'(NUM_ROOMS - 1);

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t            state, state_n;
  logic [XW-1:0]     x_off, x_off_n;
  logic [MW-1:0]     moved, moved_n;
  logic [MW-1:0]     rem, d;
  logic              dir, dir_n;
  logic [RW-1:0]     room_n;
  logic              busy_n, done_n;

  logic [9:0]        cx, cy, cx_c, cy_c;
  logic [ADDR_W-1:0] addr_n;
  logic              en_d1, en_d2;

  // Clamp the room-local coordinate so the strip is never overrun
  always_comb begin
    cx = DrawX >> SCALE_SH;
    cy = DrawY >> SCALE_SH;
    cx_c = (cx > CX_MAX) ? CX_MAX : cx;
    cy_c = (cy > CY_MAX) ? CY_MAX : cy;
    addr_n = ADDR_W'(cy_c) * SW_A
           + ADDR_W'(cx_c)
           + ADDR_W'(x_off);
  end

  always_comb begin
    state_n = state;
    x_off_n = x_off;
    moved_n = moved;
    dir_n   = dir;
    room_n  = room;
    busy_n  = busy;
    done_n  = 1'b0;
    rem     = IMG_W_M - moved;
    d       = (rem < STEP_M) ? rem : STEP_M;
    unique case (state)
      IDLE: begin
        if (scroll_req &&
            ((!scroll_dir && room < LAST_ROOM) ||
             (scroll_dir && room != '0))) begin
          dir_n   = scroll_dir;
          moved_n = '0;
          busy_n  = 1'b1;
          state_n = SCROLL;
        end
      end
      SCROLL: begin
        if (frame_tick) begin
          x_off_n = dir ? x_off - XW'(d)
                        : x_off + XW'(d);
          moved_n = moved + d;
          if (moved + d == IMG_W_M) begin
            room_n  = dir ? room - RW'(1)
                          : room + RW'(1);
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      x_off       <= '0;
      moved       <= '0;
      dir         <= 1'b0;
      room        <= '0;
      busy        <= 1'b0;
      scroll_done <= 1'b0;
    end else begin
      state       <= state_n;
      x_off       <= x_off_n;
      moved       <= moved_n;
      dir         <= dir_n;
      room        <= room_n;
      busy        <= busy_n;
      scroll_done <= done_n;
    end
  end

`ifdef BG_BORDER_EN
  localparam logic [9:0] XLAST = 10'((IMG_W << SCALE_SH) - 1);
  localparam logic [9:0] YLAST = 10'((IMG_H << SCALE_SH) - 1);

  logic [9:0] x_d1, x_d2, y_d1, y_d2;
  logic       on_edge;

  assign on_edge = (x_d2 == '0) || (x_d2 == XLAST) ||
                   (y_d2 == '0) || (y_d2 == YLAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_d1 <= '0;
      x_d2 <= '0;
      y_d1 <= '0;
      y_d2 <= '0;
    end else begin
      x_d1 <= DrawX;
      x_d2 <= x_d1;
      y_d1 <= DrawY;
      y_d2 <= y_d1;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      en_d1     <= 1'b0;
      en_d2     <= 1'b0;
      pal_index <= '0;
      pal_valid <= 1'b0;
    end else begin
      rom_addr  <= addr_n;
      en_d1     <= display_en;
      en_d2     <= en_d1;
      pal_valid <= en_d2;
`ifdef BG_BORDER_EN
      pal_index <= !en_d2 ? 5'd0 :
                   on_edge ? 5'd11 : rom_data;
`else
      pal_index <= en_d2 ? rom_data : 5'd0;
`endif
    end
  end

endmodule

// File: tb/tb_bg_scroll_fetch.sv
// Self-checking bench for bg_scroll_fetch (STEP=4 and STEP=7 instances).
// Build with +define+BG_BORDER_EN to exercise the border variant.
module tb_bg_scroll_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        display_en, frame_tick;
  logic        scroll_req, scroll_dir;
  logic [16:0] ra4, ra7;
  logic [4:0]  rd4, rd7, pi4, pi7;
  logic        pv4, pv7, busy4, busy7;
  logic        done4, done7;
  logic [1:0]  room4, room7;
  logic        rom_force;
  logic [4:0]  rom_forced;

  int ntot = 0;
  int npass = 0;

  always #5 Clk = ~Clk;

  bg_scroll_fetch dut4 (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .display_en(display_en), .frame_tick(frame_tick),
    .scroll_req(scroll_req), .scroll_dir(scroll_dir),
    .rom_addr(ra4), .rom_data(rd4), .pal_index(pi4),
    .pal_valid(pv4), .busy(busy4), .scroll_done(done4),
    .room(room4)
  );

  bg_scroll_fetch #(.STEP(7)) dut7 (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .display_en(display_en), .frame_tick(frame_tick),
    .scroll_req(scroll_req), .scroll_dir(scroll_dir),
    .rom_addr(ra7), .rom_data(rd7), .pal_index(pi7),
    .pal_valid(pv7), .busy(busy7), .scroll_done(done7),
    .room(room7)
  );

  function automatic logic [4:0] romf(input logic [16:0] a);
    return a[4:0] ^ a[9:5] ^ a[14:10];
  endfunction

  // Synchronous ROM model: data one cycle after the address
  always @(posedge Clk) begin
    rd4 <= rom_force ? rom_forced : romf(ra4);
    rd7 <= rom_force ? rom_forced : romf(ra7);
  end

  function automatic int addr_ref(int x, int y, int xoff);
    int sx, sy;
    sx = x / 4;
    sy = y / 4;
    if (sx > 159) sx = 159;
    if (sy > 119) sy = 119;
    return sy * 640 + sx + xoff;
  endfunction

  function automatic bit on_border(int x, int y);
    return x == 0 || x == 639 || y == 0 || y == 479;
  endfunction

  function automatic int pal_ref(int x, int y, bit en, int rd);
    if (!en) return 0;
`ifdef BG_BORDER_EN
    if (on_border(x, y)) return 11;
`endif
    return rd;
  endfunction

  function automatic int xexp(int base, bit dir, int k, int s);
    int m;
    m = k * s;
    if (m > 160) m = 160;
    return dir ? base - m : base + m;
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic run_scroll(input bit dir, input int base,
                            input bit coincide, input int interfere);
    int nf4, nf7, r0, r1;
    nf4 = (160 + 3) / 4;
    nf7 = (160 + 6) / 7;
    r0 = base / 160;
    r1 = dir ? r0 - 1 : r0 + 1;
    scroll_req = 1'b1;
    scroll_dir = dir;
    frame_tick = coincide;
    cyc();
    scroll_req = 1'b0;
    frame_tick = 1'b0;
    chk("busy4_start", busy4, 1);
    chk("busy7_start", busy7, 1);
    cyc();
    chk("xoff4_start", ra4, base);
    chk("xoff7_start", ra7, base);
    for (int k = 1; k <= 40; k++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      chk("busy4", busy4, int'(k < nf4));
      chk("done4", done4, int'(k == nf4));
      chk("room4", room4, (k >= nf4) ? r1 : r0);
      chk("busy7", busy7, int'(k < nf7));
      chk("done7", done7, int'(k == nf7));
      chk("room7", room7, (k >= nf7) ? r1 : r0);
      if (k == interfere) begin
        scroll_req = 1'b1;
        scroll_dir = ~dir;
      end
      cyc();
      scroll_req = 1'b0;
      chk("xoff4", ra4, xexp(base, dir, k, 4));
      chk("xoff7", ra7, xexp(base, dir, k, 7));
      chk("done4_pulse", done4, 0);
      chk("done7_pulse", done7, 0);
    end
  endtask

  typedef struct {
    int x;
    int y;
    bit en;
    int rd;
    int addr;
    int pal;
  } vec_t;

  vec_t tbl[7];
  int ex[200], ey[200];
  bit een[200];

  initial begin
    tbl[0] = '{8, 4, 1'b1, 7, 642, 7};
    tbl[1] = '{0, 0, 1'b0, 19, 0, 0};
    tbl[2] = '{639, 479, 1'b1, 5, 76319, 5};
    tbl[3] = '{1023, 1023, 1'b1, 3, 76319, 3};
    tbl[4] = '{700, 10, 1'b1, 31, 1439, 31};
    tbl[5] = '{4, 8, 1'b0, 9, 1281, 0};
    tbl[6] = '{100, 200, 1'b1, 12, 32025, 12};

    Reset = 1'b1;
    DrawX = '0;
    DrawY = '0;
    display_en = 1'b0;
    frame_tick = 1'b0;
    scroll_req = 1'b0;
    scroll_dir = 1'b0;
    rom_force = 1'b0;
    rom_forced = '0;
    cyc();
    cyc();
    chk("rst_addr", ra4, 0);
    chk("rst_pal", pi4, 0);
    chk("rst_valid", pv4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_room", room4, 0);
    Reset = 1'b0;
    cyc();

    rom_force = 1'b1;
    for (int i = 0; i < 7; i++) begin
      int ep;
      DrawX = 10'(tbl[i].x);
      DrawY = 10'(tbl[i].y);
      display_en = tbl[i].en;
      rom_forced = 5'(tbl[i].rd);
      cyc();
      chk("tbl_addr", ra4, tbl[i].addr);
      cyc();
      cyc();
      ep = tbl[i].pal;
`ifdef BG_BORDER_EN
      if (tbl[i].en && on_border(tbl[i].x, tbl[i].y)) ep = 11;
`endif
      chk("tbl_pal", pi4, ep);
      chk("tbl_valid", pv4, int'(tbl[i].en));
    end

    display_en = 1'b0;
    DrawX = 10'd8;
    DrawY = 10'd4;
    rom_forced = 5'd7;
    repeat (3) cyc();
    display_en = 1'b1;
    cyc();
    display_en = 1'b0;
    chk("lat_n1", pv4, 0);
    cyc();
    chk("lat_n2", pv4, 0);
    cyc();
    chk("lat_n3_valid", pv4, 1);
    chk("lat_n3_pal", pi4, 7);
    cyc();
    chk("lat_n4_valid", pv4, 0);
    chk("lat_n4_pal", pi4, 0);
    rom_force = 1'b0;

    DrawX = '0;
    DrawY = '0;
    scroll_req = 1'b1;
    scroll_dir = 1'b1;
    cyc();
    scroll_req = 1'b0;
    chk("ill_busy4", busy4, 0);
    chk("ill_busy7", busy7, 0);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    cyc();
    chk("ill_xoff4", ra4, 0);
    chk("ill_room4", room4, 0);

    run_scroll(1'b0, 0, 1'b0, 20);
    DrawX = '0;
    DrawY = '0;
    cyc();
    chk("r1_addr00_4", ra4, 160);
    chk("r1_addr00_7", ra7, 160);

    for (int i = 0; i < 200; i++) begin
      ex[i] = $urandom_range(0, 700);
      ey[i] = $urandom_range(0, 520);
      een[i] = 1'($urandom_range(0, 1));
      DrawX = 10'(ex[i]);
      DrawY = 10'(ey[i]);
      display_en = een[i];
      cyc();
      chk("rnd_addr4", ra4, addr_ref(ex[i], ey[i], 160));
      chk("rnd_addr7", ra7, addr_ref(ex[i], ey[i], 160));
      if (i >= 2) begin
        int a;
        a = addr_ref(ex[i-2], ey[i-2], 160);
        chk("rnd_pal", pi4,
            pal_ref(ex[i-2], ey[i-2], een[i-2],
                    int'(romf(17'(a)))));
        chk("rnd_valid", pv4, int'(een[i-2]));
      end
    end
    display_en = 1'b0;
    DrawX = '0;
    DrawY = '0;
    cyc();

    run_scroll(1'b1, 160, 1'b1, 5);

    scroll_req = 1'b1;
    scroll_dir = 1'b0;
    cyc();
    scroll_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
    chk("mid_xoff4", ra4, 40);
    chk("mid_busy4", busy4, 1);
    rom_force = 1'b1;
    rom_forced = 5'd5;
    DrawX = 10'd40;
    DrawY = 10'd40;
    display_en = 1'b1;
    repeat (3) cyc();
    chk("mid_valid", pv4, 1);
    Reset = 1'b1;
    cyc();
    chk("mrst_addr4", ra4, 0);
    chk("mrst_room4", room4, 0);
    chk("mrst_busy4", busy4, 0);
    chk("mrst_busy7", busy7, 0);
    chk("mrst_pal", pi4, 0);
    chk("mrst_valid", pv4, 0);
    Reset = 1'b0;
    rom_force = 1'b0;
    display_en = 1'b0;
    DrawX = '0;
    DrawY = '0;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    cyc();
    chk("post_xoff4", ra4, 0);
    chk("post_xoff7", ra7, 0);
    chk("post_busy4", busy4, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
